// File: rtl/cnt_enable_gen.sv
// Programmable enable-pulse generator feeding the 8-bit down counter: continuous or N-pulse burst.
// Optional hold input is compiled in with CNT_ENABLE_GEN_HOLD_EN.
module cnt_enable_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
`ifdef CNT_ENABLE_GEN_HOLD_EN
  input  logic               hold,
`endif
  input  logic               mode,
  input  logic [DIV_W-1:0]   div_value,
  input  logic [BURST_W-1:0] burst_len,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulses_left
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_q, div_nxt;
  logic [DIV_W-1:0]   presc, presc_nxt;
  logic               mode_q, mode_nxt;
  logic               enable_nxt, busy_nxt, done_nxt;
  logic [BURST_W-1:0] left_nxt;
  logic               hold_act;

`ifdef CNT_ENABLE_GEN_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_q;
    mode_nxt   = mode_q;
    presc_nxt  = presc;
    left_nxt   = pulses_left;
    enable_nxt = 1'b0;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          div_nxt   = div_value;
          mode_nxt  = mode;
          presc_nxt = div_value;
          left_nxt  = mode ? burst_len : '0;
          // A zero-length burst completes without ever entering RUN.
          if (mode && (burst_len == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          left_nxt  = '0;
        end else if (hold_act) begin
          busy_nxt = 1'b1;
        end else if (presc == '0) begin
          enable_nxt = 1'b1;
          presc_nxt  = div_q;
          busy_nxt   = 1'b1;
          if (mode_q) begin
            left_nxt = pulses_left - BURST_W'(1);
            // Final pulse: busy falls in the same cycle the last enable is seen.
            if (pulses_left == BURST_W'(1)) begin
              state_nxt = DONE;
              busy_nxt  = 1'b0;
            end
          end
        end else begin
          presc_nxt = presc - DIV_W'(1);
          busy_nxt  = 1'b1;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      div_q       <= '0;
      mode_q      <= 1'b0;
      presc       <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
    end else begin
      state       <= state_nxt;
      div_q       <= div_nxt;
      mode_q      <= mode_nxt;
      presc       <= presc_nxt;
      enable      <= enable_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pulses_left <= left_nxt;
    end
  end

endmodule
